axi_sram_slave: RTL and testbench
=================================

Name: axi_sram_slave

Overview:
- AXI4 slave backed by an internal word-addressed memory, sitting directly downstream of the bench AXI master.
- Consumes its write and read bursts.
- Supports FIXED, INCR and WRAP bursts, byte strobes and address-window decode with DECERR.
- Write and read paths are independent; each has one outstanding transaction.

Parameters:
- AXI_ID_WIDTH, 1, ID width; IDs are echoed on B and R.
- AXI_DATA_WIDTH, 32, data width; only 32 is supported.
- AXI_ADDR_WIDTH, 32, address width.
- MEM_ADDR_WIDTH, 10, log2 of memory depth in 32-bit words (window = 4*2^MEM_ADDR_WIDTH bytes).
- BASE_ADDR, 32'h9000_0000, window base; must be aligned to the window size.

Ports:
- aclk  in  1  clock, rising edge.
- areset  in  1  asynchronous, active-high reset.
- axi_awid  in  AXI_ID_WIDTH  write ID.
- axi_awaddr  in  AXI_ADDR_WIDTH  write start address.
- axi_awlen  in  8  beats-1.
- axi_awsize  in  3  beat size.
- axi_awburst  in  2  burst type.
- axi_awvalid  in  1  AW valid.
- axi_awready  out  1  AW ready.
- axi_wdata  in  32  write data.
- axi_wstrb  in  4  byte enables.
- axi_wlast  in  1  last write beat.
- axi_wvalid  in  1  W valid.
- axi_wready  out  1  W ready.
- axi_bid  out  AXI_ID_WIDTH  response ID.
- axi_bresp  out  2  write response.
- axi_bvalid  out  1  B valid.
- axi_bready  in  1  B ready.
- axi_arid  in  AXI_ID_WIDTH  read ID.
- axi_araddr  in  AXI_ADDR_WIDTH  read start address.
- axi_arlen  in  8  beats-1.
- axi_arsize  in  3  beat size.
- axi_arburst  in  2  burst type.
- axi_arvalid  in  1  AR valid.
- axi_arready  out  1  AR ready.
- axi_rid  out  AXI_ID_WIDTH  read ID.
- axi_rdata  out  32  read data.
- axi_rresp  out  2  read response.
- axi_rlast  out  1  last read beat.
- axi_rvalid  out  1  R valid.
- axi_rready  in  1  R ready.

Behaviour:
- Reset: one clock (aclk); areset is asynchronous and active-high.
  - During reset, all outputs are 0 except axi_awready=1 and axi_arready=1 (idle).
  - Both FSMs return to IDLE, including mid-burst; the in-flight burst is abandoned with no B/R.
  - Memory contents are not reset.
- Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
  - W_IDLE: awready=1. AW handshake latches id, addr, len, burst, error flags, and clears the beat count.
  - W_DATA: wready=1, awready=0. Each W handshake (wvalid&wready) writes the enabled bytes, advances the address and increments the count. Gaps in wvalid are legal.
  - After beat len+1: go to W_RESP.
  - W_RESP: bvalid=1 with bid/bresp held stable until bready. Then W_IDLE, awready=1 on the next cycle.
- Read FSM R_IDLE -> R_DATA -> R_IDLE.
  - R_IDLE: arready=1. AR handshake at edge N latches the request and registers beat 0 data; rvalid=1 from N+1.
  - R_DATA: rdata/rresp/rlast are held while rvalid&!rready. Each handshake loads the next beat, giving 1 beat/cycle sustained.
  - rlast=1 only on beat len+1. Its handshake returns to R_IDLE, with arready=1 on the next cycle.
- Address generation (per beat, byte address, 4-byte beats):
  - FIXED (00): address unchanged.
  - INCR (01): +4.
  - WRAP (10): addr = (addr & ~M) | ((addr+4) & M), M = 4*(len+1)-1.
  - Memory index = addr[MEM_ADDR_WIDTH+1:2]. INCR past the window end wraps modulo the window; no 4KB check.
- Error checks (evaluated at the AX handshake):
  - Decode miss: addr[AXI_ADDR_WIDTH-1:MEM_ADDR_WIDTH+2] != BASE_ADDR same bits -> DECERR (11).
  - Slave error -> SLVERR (10) when any of: size != 3'b010; burst == 11; WRAP with len not in {1,3,7,15}.
  - DECERR takes priority over SLVERR.
  - An erroring write still accepts all len+1 beats but writes nothing.
  - An erroring read returns len+1 beats of rdata=0, each carrying the error resp, with a correct rlast.
- wlast check: wlast present on a non-final beat, or missing on the final beat, sets bresp=SLVERR. Data is still written; the beat count alone ends the burst.
- OKAY (00) otherwise.
- Simultaneous read and write to the same word on the same edge: the read returns old data.
- Simultaneous AW and AR handshakes are both accepted.

Decomposition:
- Package axi_pkg holds:
  - BURST_FIXED/INC/WRAP
  - RESP_OKAY/EXOKAY/SLVERR/DECERR
  - SIZE_4B
  - a next-address function
- One sub-module, axi_burst_addr_gen: combinational next-address generation from addr, len, burst. Instantiated twice (write and read).

Test Plan:
- INCR write, 32 beats at 0x9000_0000 (data 0x64343962, 0x39623732, ...) with wvalid dropped after every beat -> bresp=00. Then an 8-beat read at 0x9000_0000 returns the first 8 words, rlast only on beat 8.
- Write 32 beats at 0x1000_0000 -> all beats accepted, bresp=11, memory unchanged. A 32-beat read there returns 32x 0 with rresp=11, rlast on beat 32.
- WRAP 4-beat write at 0x9000_0008 with data A,B,C,D -> words at byte offsets 8,C,0,4 hold A,B,C,D. A WRAP read returns A,B,C,D.
- Write word 0x11223344 with wstrb=4'b0101 over 0xFFFFFFFF -> readback is 0xFF22FF44. Write with awsize=3'b001 -> bresp=10, memory unchanged.
- rready held low 3 cycles mid-burst -> rdata/rlast stable. bready delayed 5 cycles -> bvalid and bresp held. bid/rid echo ID 1.
- areset pulsed during beat 3 of 8-beat read -> rvalid=0 asynchronously, arready=1. A new read succeeds and earlier written data is intact.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI encodings, FSM state types and burst next-address arithmetic.
package axi_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  localparam logic [2:0] SIZE_4B = 3'b010;

  typedef enum logic [1:0] {
    WIdle,
    WData,
    WResp
  } w_state_e;

  typedef enum logic {
    RIdle,
    RData
  } r_state_e;

  // Byte address of the following 4-byte beat. WRAP assumes a legal length,
  // so the mask 4*(len+1)-1 is a contiguous run of low ones.
  function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [7:0] len,
                                            input logic [1:0] burst);
    logic [31:0] incr;
    logic [31:0] mask;
    logic [31:0] result;
    incr = addr + 32'd4;
    mask = ({22'd0, len, 2'b00} + 32'd4) - 32'd1;
    case (burst)
      BURST_FIXED: result = addr;
      BURST_WRAP:  result = (addr & ~mask) | (incr & mask);
      default:     result = incr;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/axi_sram_slave_if.sv
// AXI4 write/read channel bundle between the bench master and the SRAM slave.
interface axi_sram_slave_if #(
  parameter int unsigned ID_WIDTH   = 1,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
);
  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;
  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ID_WIDTH-1:0]     arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arvalid;
  logic                    arready;
  logic [ID_WIDTH-1:0]     rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi_burst_addr_gen.sv
// Combinational next-beat address for FIXED/INCR/WRAP bursts of 4-byte beats.
module axi_burst_addr_gen
  import axi_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [7:0]            len,
  input  logic [1:0]            burst,
  output logic [ADDR_WIDTH-1:0] addr_next
);

  assign addr_next = ADDR_WIDTH'(next_addr(32'(addr), len, burst));

endmodule

// File: rtl/axi_sram_slave.sv
// AXI4 slave over a word-addressed SRAM; independent write and read paths,
// one outstanding burst each, with decode (DECERR) and protocol (SLVERR) checks.
module axi_sram_slave
  import axi_pkg::*;
#(
  parameter int unsigned AXI_ID_WIDTH   = 1,
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned MEM_ADDR_WIDTH = 10,
  parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR = 32'h9000_0000
) (
  input logic             aclk,
  input logic             areset,
  axi_sram_slave_if.slave axi
);

  localparam int unsigned STRB_WIDTH = AXI_DATA_WIDTH / 8;
  localparam int unsigned TAG_WIDTH  = AXI_ADDR_WIDTH - MEM_ADDR_WIDTH - 2;
  localparam int unsigned DEPTH      = 2 ** MEM_ADDR_WIDTH;

  // Decode miss wins over any protocol violation.
  function automatic logic [1:0] ax_resp(input logic [TAG_WIDTH-1:0] tag, input logic [7:0] len,
                                         input logic [2:0] size, input logic [1:0] burst);
    logic [1:0] resp;
    resp = RESP_OKAY;
    if (size != SIZE_4B || burst == BURST_RSVD ||
        (burst == BURST_WRAP && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}))) begin
      resp = RESP_SLVERR;
    end
    if (tag != BASE_ADDR[AXI_ADDR_WIDTH-1:MEM_ADDR_WIDTH+2]) begin
      resp = RESP_DECERR;
    end
    return resp;
  endfunction

  logic [AXI_DATA_WIDTH-1:0] mem [DEPTH];

  // Write path state
  w_state_e                  w_state_q, w_state_d;
  logic [AXI_ID_WIDTH-1:0]   w_id_q;
  logic [AXI_ADDR_WIDTH-1:0] w_addr_q, w_addr_next;
  logic [7:0]                w_len_q, w_cnt_q;
  logic [1:0]                w_burst_q, w_err_q, aw_err;
  logic                      w_last_err_q;
  logic                      mem_we;

  // Read path state
  r_state_e                  r_state_q, r_state_d;
  logic [AXI_ID_WIDTH-1:0]   r_id_q;
  logic [AXI_ADDR_WIDTH-1:0] r_addr_q, r_addr_next;
  logic [7:0]                r_len_q, r_cnt_q;
  logic [1:0]                r_burst_q, r_err_q, ar_err;
  logic [AXI_DATA_WIDTH-1:0] r_data_q;
  logic                      r_last;

  assign aw_err = ax_resp(axi.awaddr[AXI_ADDR_WIDTH-1:MEM_ADDR_WIDTH+2], axi.awlen, axi.awsize,
                          axi.awburst);
  assign ar_err = ax_resp(axi.araddr[AXI_ADDR_WIDTH-1:MEM_ADDR_WIDTH+2], axi.arlen, axi.arsize,
                          axi.arburst);

  axi_burst_addr_gen #(
    .ADDR_WIDTH(AXI_ADDR_WIDTH)
  ) u_w_addr_gen (
    .addr     (w_addr_q),
    .len      (w_len_q),
    .burst    (w_burst_q),
    .addr_next(w_addr_next)
  );

  axi_burst_addr_gen #(
    .ADDR_WIDTH(AXI_ADDR_WIDTH)
  ) u_r_addr_gen (
    .addr     (r_addr_q),
    .len      (r_len_q),
    .burst    (r_burst_q),
    .addr_next(r_addr_next)
  );

  // Write FSM state register
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) w_state_q <= WIdle;
    else        w_state_q <= w_state_d;
  end

  // Write FSM next state and handshake outputs
  always_comb begin
    w_state_d   = w_state_q;
    axi.awready = 1'b0;
    axi.wready  = 1'b0;
    axi.bvalid  = 1'b0;
    unique case (w_state_q)
      WIdle: begin
        axi.awready = 1'b1;
        if (axi.awvalid) w_state_d = WData;
      end
      WData: begin
        axi.wready = 1'b1;
        if (axi.wvalid && w_cnt_q == w_len_q) w_state_d = WResp;
      end
      WResp: begin
        axi.bvalid = 1'b1;
        if (axi.bready) w_state_d = WIdle;
      end
      default: w_state_d = WIdle;
    endcase
  end

  // Write request latch and per-beat address/count/wlast tracking
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      w_id_q       <= '0;
      w_addr_q     <= '0;
      w_len_q      <= '0;
      w_burst_q    <= '0;
      w_err_q      <= '0;
      w_cnt_q      <= '0;
      w_last_err_q <= 1'b0;
    end else if (w_state_q == WIdle && axi.awvalid) begin
      w_id_q       <= axi.awid;
      w_addr_q     <= axi.awaddr;
      w_len_q      <= axi.awlen;
      w_burst_q    <= axi.awburst;
      w_err_q      <= aw_err;
      w_cnt_q      <= '0;
      w_last_err_q <= 1'b0;
    end else if (w_state_q == WData && axi.wvalid) begin
      w_addr_q <= w_addr_next;
      w_cnt_q  <= w_cnt_q + 8'd1;
      if (axi.wlast != (w_cnt_q == w_len_q)) w_last_err_q <= 1'b1;
    end
  end

  // A bad wlast still writes; only request errors suppress the store.
  assign mem_we    = (w_state_q == WData) && axi.wvalid && (w_err_q == RESP_OKAY);
  assign axi.bid   = w_id_q;
  assign axi.bresp = (w_err_q != RESP_OKAY) ? w_err_q :
                     (w_last_err_q ? RESP_SLVERR : RESP_OKAY);

  // Byte-enabled memory store; contents survive reset
  always_ff @(posedge aclk) begin
    if (mem_we) begin
      for (int b = 0; b < int'(STRB_WIDTH); b++) begin
        if (axi.wstrb[b]) mem[w_addr_q[MEM_ADDR_WIDTH+1:2]][8*b +: 8] <= axi.wdata[8*b +: 8];
      end
    end
  end

  // Read FSM state register
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) r_state_q <= RIdle;
    else        r_state_q <= r_state_d;
  end

  // Read FSM next state and handshake outputs
  always_comb begin
    r_state_d   = r_state_q;
    axi.arready = 1'b0;
    axi.rvalid  = 1'b0;
    unique case (r_state_q)
      RIdle: begin
        axi.arready = 1'b1;
        if (axi.arvalid) r_state_d = RData;
      end
      RData: begin
        axi.rvalid = 1'b1;
        if (axi.rready && r_last) r_state_d = RIdle;
      end
      default: r_state_d = RIdle;
    endcase
  end

  assign r_last = (r_state_q == RData) && (r_cnt_q == r_len_q);

  // Read request latch; each R handshake prefetches the next beat so that
  // data sits in a register ready for back-to-back transfers.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_id_q    <= '0;
      r_addr_q  <= '0;
      r_len_q   <= '0;
      r_burst_q <= '0;
      r_err_q   <= '0;
      r_cnt_q   <= '0;
      r_data_q  <= '0;
    end else if (r_state_q == RIdle && axi.arvalid) begin
      r_id_q    <= axi.arid;
      r_addr_q  <= axi.araddr;
      r_len_q   <= axi.arlen;
      r_burst_q <= axi.arburst;
      r_err_q   <= ar_err;
      r_cnt_q   <= '0;
      r_data_q  <= (ar_err != RESP_OKAY) ? '0 : mem[axi.araddr[MEM_ADDR_WIDTH+1:2]];
    end else if (r_state_q == RData && axi.rready && !r_last) begin
      r_addr_q <= r_addr_next;
      r_cnt_q  <= r_cnt_q + 8'd1;
      r_data_q <= (r_err_q != RESP_OKAY) ? '0 : mem[r_addr_next[MEM_ADDR_WIDTH+1:2]];
    end
  end

  assign axi.rid   = r_id_q;
  assign axi.rdata = r_data_q;
  assign axi.rresp = r_err_q;
  assign axi.rlast = r_last;

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave: single-beat vector table plus burst sequences.
module tb_axi_sram_slave;
  import axi_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axi_sram_slave_if #(.ID_WIDTH(1), .DATA_WIDTH(32), .ADDR_WIDTH(32)) axi ();

  axi_sram_slave #(
    .AXI_ID_WIDTH  (1),
    .AXI_DATA_WIDTH(32),
    .AXI_ADDR_WIDTH(32),
    .MEM_ADDR_WIDTH(10),
    .BASE_ADDR     (32'h9000_0000)
  ) dut (
    .aclk  (clk),
    .areset(rst),
    .axi   (axi.slave)
  );

  localparam int Limit = 200;

  int nvec = 0;
  int nfail = 0;
  logic [31:0] wbuf [256];
  logic [31:0] ebuf [256];

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  burst;
    logic [2:0]  size;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [1:0]  exp_bresp;
    logic [31:0] raddr;
    logic [31:0] exp_rdata;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Burst data pattern for the long INCR test.
  function automatic logic [31:0] sword(input int i);
    if (i == 0) return 32'h6434_3962;
    if (i == 1) return 32'h3962_3732;
    return 32'h3000_0000 + 32'(i) * 32'h0000_0101;
  endfunction

  task automatic do_write(input logic id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input logic [2:0] size, input logic [3:0] strb,
                          input bit gap, input int bad_beat, input int bdelay,
                          input logic [1:0] exp_resp);
    int t;
    @(negedge clk);
    axi.awid = id; axi.awaddr = addr; axi.awlen = len; axi.awsize = size;
    axi.awburst = burst; axi.awvalid = 1'b1;
    t = 0;
    while (!axi.awready && t < Limit) begin @(negedge clk); t++; end
    if (t >= Limit) begin check("aw_timeout", 32'd0, 32'd1); return; end
    @(negedge clk);
    axi.awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      axi.wdata = wbuf[i]; axi.wstrb = strb;
      axi.wlast = (i == int'(len)) ^ (i == bad_beat);
      axi.wvalid = 1'b1;
      t = 0;
      while (!axi.wready && t < Limit) begin @(negedge clk); t++; end
      if (t >= Limit) begin check("w_timeout", 32'd0, 32'd1); axi.wvalid = 1'b0; return; end
      @(negedge clk);
      axi.wvalid = 1'b0;
      if (gap) @(negedge clk);
    end
    t = 0;
    while (!axi.bvalid && t < Limit) begin @(negedge clk); t++; end
    if (t >= Limit) begin check("b_timeout", 32'd0, 32'd1); return; end
    for (int k = 0; k < bdelay; k++) begin
      check("bvalid_hold", 32'(axi.bvalid), 32'd1);
      check("bresp_hold", 32'(axi.bresp), 32'(exp_resp));
      @(negedge clk);
    end
    axi.bready = 1'b1;
    check("bvalid", 32'(axi.bvalid), 32'd1);
    check("bresp", 32'(axi.bresp), 32'(exp_resp));
    check("bid", 32'(axi.bid), 32'(id));
    @(negedge clk);
    axi.bready = 1'b0;
    check("b_done", 32'(axi.bvalid), 32'd0);
    check("awready_after_b", 32'(axi.awready), 32'd1);
  endtask

  task automatic check_beat(input int i, input logic id, input logic [7:0] len,
                            input logic [1:0] exp_resp);
    check("rvalid", 32'(axi.rvalid), 32'd1);
    check("rdata", axi.rdata, ebuf[i]);
    check("rresp", 32'(axi.rresp), 32'(exp_resp));
    check("rlast", 32'(axi.rlast), 32'(i == int'(len)));
    check("rid", 32'(axi.rid), 32'(id));
  endtask

  task automatic do_read(input logic id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input logic [1:0] exp_resp,
                         input int stall_beat, input int rst_beat);
    int t;
    @(negedge clk);
    axi.arid = id; axi.araddr = addr; axi.arlen = len; axi.arsize = SIZE_4B;
    axi.arburst = burst; axi.arvalid = 1'b1;
    t = 0;
    while (!axi.arready && t < Limit) begin @(negedge clk); t++; end
    if (t >= Limit) begin check("ar_timeout", 32'd0, 32'd1); return; end
    @(negedge clk);
    axi.arvalid = 1'b0;
    axi.rready = 1'b1;
    for (int i = 0; i <= int'(len); i++) begin
      t = 0;
      while (!axi.rvalid && t < Limit) begin @(negedge clk); t++; end
      if (t >= Limit) begin check("r_timeout", 32'd0, 32'd1); axi.rready = 1'b0; return; end
      if (i == rst_beat) begin
        axi.rready = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_rvalid", 32'(axi.rvalid), 32'd0);
        check("rst_arready", 32'(axi.arready), 32'd1);
        check("rst_rdata", axi.rdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      if (i == stall_beat) begin
        axi.rready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          @(negedge clk);
          check_beat(i, id, len, exp_resp);
        end
        axi.rready = 1'b1;
      end
      check_beat(i, id, len, exp_resp);
      @(negedge clk);
    end
    axi.rready = 1'b0;
    check("r_done", 32'(axi.rvalid), 32'd0);
  endtask

  vec_t vt[8];

  initial begin
    vt[0] = '{32'h9000_0100, BURST_INCR, 3'b010, 4'hF, 32'hFFFF_FFFF, RESP_OKAY,
              32'h9000_0100, 32'hFFFF_FFFF};
    vt[1] = '{32'h9000_0100, BURST_INCR, 3'b010, 4'b0101, 32'h1122_3344, RESP_OKAY,
              32'h9000_0100, 32'hFF22_FF44};
    vt[2] = '{32'h9000_0100, BURST_INCR, 3'b001, 4'hF, 32'hDEAD_BEEF, RESP_SLVERR,
              32'h9000_0100, 32'hFF22_FF44};
    vt[3] = '{32'h9000_0100, BURST_RSVD, 3'b010, 4'hF, 32'hDEAD_BEEF, RESP_SLVERR,
              32'h9000_0100, 32'hFF22_FF44};
    vt[4] = '{32'h9000_0100, BURST_WRAP, 3'b010, 4'hF, 32'hDEAD_BEEF, RESP_SLVERR,
              32'h9000_0100, 32'hFF22_FF44};
    vt[5] = '{32'h9000_1100, BURST_INCR, 3'b010, 4'hF, 32'hDEAD_BEEF, RESP_DECERR,
              32'h9000_0100, 32'hFF22_FF44};
    vt[6] = '{32'h8000_0100, BURST_INCR, 3'b001, 4'hF, 32'hDEAD_BEEF, RESP_DECERR,
              32'h9000_0100, 32'hFF22_FF44};
    vt[7] = '{32'h9000_0FFC, BURST_INCR, 3'b010, 4'hF, 32'hCAFE_F00D, RESP_OKAY,
              32'h9000_0FFC, 32'hCAFE_F00D};

    axi.awid = '0; axi.awaddr = '0; axi.awlen = '0; axi.awsize = '0; axi.awburst = '0;
    axi.awvalid = 1'b0; axi.wdata = '0; axi.wstrb = '0; axi.wlast = 1'b0; axi.wvalid = 1'b0;
    axi.bready = 1'b0; axi.arid = '0; axi.araddr = '0; axi.arlen = '0; axi.arsize = '0;
    axi.arburst = '0; axi.arvalid = 1'b0; axi.rready = 1'b0;

    // Reset state
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_awready", 32'(axi.awready), 32'd1);
    check("rst_arready", 32'(axi.arready), 32'd1);
    check("rst_wready", 32'(axi.wready), 32'd0);
    check("rst_bvalid", 32'(axi.bvalid), 32'd0);
    check("rst_rvalid", 32'(axi.rvalid), 32'd0);
    check("rst_rlast", 32'(axi.rlast), 32'd0);
    rst = 1'b0;

    // 32-beat INCR write with wvalid gaps, then 8-beat readback
    for (int i = 0; i < 32; i++) wbuf[i] = sword(i);
    do_write(1'b0, 32'h9000_0000, 8'd31, BURST_INCR, SIZE_4B, 4'hF, 1'b1, -1, 0, RESP_OKAY);
    for (int i = 0; i < 8; i++) ebuf[i] = sword(i);
    do_read(1'b0, 32'h9000_0000, 8'd7, BURST_INCR, RESP_OKAY, -1, -1);

    // Out-of-window burst: accepted, DECERR, no store; reads return zeros
    for (int i = 0; i < 32; i++) wbuf[i] = ~sword(i);
    do_write(1'b0, 32'h1000_0000, 8'd31, BURST_INCR, SIZE_4B, 4'hF, 1'b0, -1, 0, RESP_DECERR);
    do_read(1'b0, 32'h9000_0000, 8'd7, BURST_INCR, RESP_OKAY, -1, -1);
    for (int i = 0; i < 32; i++) ebuf[i] = 32'd0;
    do_read(1'b0, 32'h1000_0000, 8'd31, BURST_INCR, RESP_DECERR, -1, -1);

    // Single-beat table: strobes, SLVERR/DECERR suppression, window top
    for (int v = 0; v < 8; v++) begin
      wbuf[0] = vt[v].wdata;
      do_write(1'b0, vt[v].addr, 8'd0, vt[v].burst, vt[v].size, vt[v].strb, 1'b0, -1, 0,
               vt[v].exp_bresp);
      ebuf[0] = vt[v].exp_rdata;
      do_read(1'b0, vt[v].raddr, 8'd0, BURST_INCR, RESP_OKAY, -1, -1);
    end

    // wlast early on beat 0 / missing on final beat: SLVERR but data written
    wbuf[0] = 32'hAAAA_0001; wbuf[1] = 32'hAAAA_0002;
    do_write(1'b0, 32'h9000_0200, 8'd1, BURST_INCR, SIZE_4B, 4'hF, 1'b0, 0, 0, RESP_SLVERR);
    wbuf[0] = 32'hAAAA_0003;
    do_write(1'b0, 32'h9000_0208, 8'd0, BURST_INCR, SIZE_4B, 4'hF, 1'b0, 0, 0, RESP_SLVERR);
    ebuf[0] = 32'hAAAA_0001; ebuf[1] = 32'hAAAA_0002; ebuf[2] = 32'hAAAA_0003;
    do_read(1'b0, 32'h9000_0200, 8'd2, BURST_INCR, RESP_OKAY, -1, -1);

    // WRAP 4-beat starting mid-block: lands at offsets 8,C,0,4
    wbuf[0] = 32'hA0A0_A0A0; wbuf[1] = 32'hB1B1_B1B1;
    wbuf[2] = 32'hC2C2_C2C2; wbuf[3] = 32'hD3D3_D3D3;
    do_write(1'b0, 32'h9000_0008, 8'd3, BURST_WRAP, SIZE_4B, 4'hF, 1'b0, -1, 0, RESP_OKAY);
    ebuf[0] = 32'hC2C2_C2C2; ebuf[1] = 32'hD3D3_D3D3;
    ebuf[2] = 32'hA0A0_A0A0; ebuf[3] = 32'hB1B1_B1B1;
    do_read(1'b0, 32'h9000_0000, 8'd3, BURST_INCR, RESP_OKAY, -1, -1);
    ebuf[0] = 32'hA0A0_A0A0; ebuf[1] = 32'hB1B1_B1B1;
    ebuf[2] = 32'hC2C2_C2C2; ebuf[3] = 32'hD3D3_D3D3;
    do_read(1'b0, 32'h9000_0008, 8'd3, BURST_WRAP, RESP_OKAY, -1, -1);

    // ID 1 echo with bready held off 5 cycles
    wbuf[0] = 32'h1357_2468;
    do_write(1'b1, 32'h9000_0300, 8'd0, BURST_INCR, SIZE_4B, 4'hF, 1'b0, -1, 5, RESP_OKAY);
    ebuf[0] = 32'h1357_2468;
    do_read(1'b1, 32'h9000_0300, 8'd0, BURST_INCR, RESP_OKAY, -1, -1);

    // rready stalls mid-burst and on the last beat
    for (int i = 0; i < 8; i++) ebuf[i] = sword(i + 8);
    do_read(1'b1, 32'h9000_0020, 8'd7, BURST_INCR, RESP_OKAY, 3, -1);
    do_read(1'b0, 32'h9000_0020, 8'd7, BURST_INCR, RESP_OKAY, 7, -1);

    // Reset during beat 3, then memory survives and a new read works
    do_read(1'b0, 32'h9000_0020, 8'd7, BURST_INCR, RESP_OKAY, -1, 3);
    do_read(1'b0, 32'h9000_0020, 8'd7, BURST_INCR, RESP_OKAY, -1, -1);
    ebuf[0] = 32'hC2C2_C2C2; ebuf[1] = 32'hD3D3_D3D3;
    ebuf[2] = 32'hA0A0_A0A0; ebuf[3] = 32'hB1B1_B1B1;
    do_read(1'b0, 32'h9000_0000, 8'd3, BURST_INCR, RESP_OKAY, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
